// File: rtl/nfca_fmt_pkg.sv
// Shared types and character constants for the NFC-A receive formatter.
// An entry is one received byte (or a no-card event) plus its frame status.
package nfca_fmt_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [3:0] lastb;
    logic       err;
    logic       col;
    logic       nocard;
  } fmt_entry_t;

  localparam int ENTRY_W = $bits(fmt_entry_t);

  typedef enum logic [3:0] {
    IDLE, HI, LO, MARK, MARKB, CR, TAIL, BIN_D, BIN_F
  } fmt_state_t;

  localparam logic [7:0] CH_ERR    = 8'h65;  // 'e'
  localparam logic [7:0] CH_COL    = 8'h63;  // 'c'
  localparam logic [7:0] CH_BITS   = 8'h3A;  // ':'
  localparam logic [7:0] CH_NOCARD = 8'h6E;  // 'n'
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  localparam logic [3:0] FULL_BYTE = 4'd8;

  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/sync_fifo_sr.sv
// First-word-fall-through synchronous FIFO, active-high synchronous reset.
// The head entry is visible on rd_data whenever empty is low; rd_en pops it.
module sync_fifo_sr #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          more
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_wr, do_rd;

  // cnt never exceeds DEPTH, so its top bit alone means full
  assign full    = cnt[AW];
  assign empty   = (cnt == '0);
  assign more    = (cnt > (AW+1)'(1));
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk)
    if (do_wr) mem[wptr] <= wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/nfca_rx_formatter.sv
// Buffers NFC-A receive events and serialises each as ASCII hex or binary
// bytes under valid/ready; the FSM formats straight from the FIFO head.
module nfca_rx_formatter
  import nfca_fmt_pkg::*;
#(
  parameter int FIFO_ASIZE = 8,
  parameter int MODE       = 0,
  parameter int CRLF       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic [3:0] in_lastb,
  input  logic       in_err,
  input  logic       in_col,
  input  logic       no_card,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       overflow,
  output logic       fifo_empty
);

  localparam fmt_state_t FIRST = (MODE == 1) ? BIN_D : HI;

  fmt_entry_t            in_ent, cap_ent, head;
  logic                  cap_valid;
  logic [ENTRY_W-1:0]    head_raw;
  logic                  fifo_full, fifo_mt, fifo_more, wr_ok, done;
  fmt_state_t            state, nxt, term_st;
  logic                  mark_en, line_end;

  always_comb begin
    in_ent = '{data: in_data, last: in_last, lastb: in_lastb,
               err: in_err, col: in_col, nocard: 1'b0};
    if (no_card)
      in_ent = '{data: 8'h00, last: 1'b1, lastb: FULL_BYTE,
                 err: 1'b0, col: 1'b0, nocard: 1'b1};
  end

  // One-cycle capture stage; the FIFO full test happens here, before any pop
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_ent   <= '0;
      overflow  <= 1'b0;
    end else begin
      cap_valid <= in_valid | no_card;
      cap_ent   <= in_ent;
      if ((in_valid & no_card) | (cap_valid & fifo_full))
        overflow <= 1'b1;
    end
  end

  assign wr_ok = cap_valid & ~fifo_full;

  sync_fifo_sr #(.DW(ENTRY_W), .AW(FIFO_ASIZE)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap_valid),
    .wr_data (cap_ent),
    .full    (fifo_full),
    .rd_en   (done),
    .rd_data (head_raw),
    .empty   (fifo_mt),
    .more    (fifo_more)
  );

  assign head       = fmt_entry_t'(head_raw);
  assign fifo_empty = fifo_mt & ~cap_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    done      = 1'b0;
    line_end  = head.last | head.nocard;
    mark_en   = head.err | head.col | (head.lastb != FULL_BYTE);
    term_st   = (line_end && CRLF == 1) ? CR : TAIL;
    unique case (state)
      IDLE:
        if (!fifo_mt) nxt = FIRST;
      HI: begin
        out_valid = 1'b1;
        out_byte  = head.nocard ? CH_NOCARD : hex2ascii(head.data[7:4]);
        if (out_ready) nxt = head.nocard ? term_st : LO;
      end
      LO: begin
        out_valid = 1'b1;
        out_byte  = hex2ascii(head.data[3:0]);
        if (out_ready) nxt = mark_en ? MARK : term_st;
      end
      MARK: begin
        out_valid = 1'b1;
        out_byte  = head.err ? CH_ERR : (head.col ? CH_COL : CH_BITS);
        if (out_ready) nxt = MARKB;
      end
      MARKB: begin
        out_valid = 1'b1;
        out_byte  = hex2ascii(head.lastb);
        if (out_ready) nxt = term_st;
      end
      CR: begin
        out_valid = 1'b1;
        out_byte  = CH_CR;
        if (out_ready) nxt = TAIL;
      end
      TAIL: begin
        out_valid = 1'b1;
        out_byte  = line_end ? CH_LF : CH_SP;
        done      = out_ready;
      end
      BIN_D: begin
        out_valid = 1'b1;
        out_byte  = head.nocard ? 8'h00 : head.data;
        if (out_ready) nxt = BIN_F;
      end
      BIN_F: begin
        out_valid = 1'b1;
        out_byte  = {head.last, head.err, head.col, head.nocard, head.lastb};
        done      = out_ready;
      end
      default: nxt = IDLE;
    endcase
    // The first emitting state depends only on MODE, so the next entry can be
    // entered before its contents reach the head (including a same-cycle write)
    if (done) nxt = (fifo_more || wr_ok) ? FIRST : IDLE;
  end

endmodule

// File: tb/tb_nfca_rx_formatter.sv
// Directed and randomised-backpressure bench for nfca_rx_formatter across
// four configurations sharing one input stream.
module tb_nfca_rx_formatter;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, in_err, in_col, no_card, out_ready;
  logic [7:0] in_data;
  logic [3:0] in_lastb;
  logic [3:0] ov, ovf, emp;
  logic [7:0] ob [4];

  always #5 clk = ~clk;

  nfca_rx_formatter #(.FIFO_ASIZE(8), .MODE(0), .CRLF(0)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_lastb(in_lastb), .in_err(in_err), .in_col(in_col), .no_card(no_card),
    .out_valid(ov[0]), .out_ready(out_ready), .out_byte(ob[0]), .overflow(ovf[0]),
    .fifo_empty(emp[0]));
  nfca_rx_formatter #(.FIFO_ASIZE(8), .MODE(0), .CRLF(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_lastb(in_lastb), .in_err(in_err), .in_col(in_col), .no_card(no_card),
    .out_valid(ov[1]), .out_ready(out_ready), .out_byte(ob[1]), .overflow(ovf[1]),
    .fifo_empty(emp[1]));
  nfca_rx_formatter #(.FIFO_ASIZE(8), .MODE(1), .CRLF(0)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_lastb(in_lastb), .in_err(in_err), .in_col(in_col), .no_card(no_card),
    .out_valid(ov[2]), .out_ready(out_ready), .out_byte(ob[2]), .overflow(ovf[2]),
    .fifo_empty(emp[2]));
  nfca_rx_formatter #(.FIFO_ASIZE(2), .MODE(0), .CRLF(0)) d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_lastb(in_lastb), .in_err(in_err), .in_col(in_col), .no_card(no_card),
    .out_valid(ov[3]), .out_ready(out_ready), .out_byte(ob[3]), .overflow(ovf[3]),
    .fifo_empty(emp[3]));

  bq_t q0, q1, q2, q3, xq, e0, e1, e2;
  int  tq0[$];
  int  cyc = 0;
  int  n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bytes are captured at the negedge preceding the accepting posedge
  always @(negedge clk) begin
    if (!rst) begin
      if (ov[0] && out_ready) begin q0.push_back(ob[0]); tq0.push_back(cyc); end
      if (ov[1] && out_ready) q1.push_back(ob[1]);
      if (ov[2] && out_ready) q2.push_back(ob[2]);
      if (ov[3] && out_ready) q3.push_back(ob[3]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input bq_t got, input bq_t exp);
    chk({tag, ".len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk($sformatf("%s[%0d]", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
  endtask

  task automatic clrq();
    q0.delete(); q1.delete(); q2.delete(); q3.delete(); tq0.delete();
  endtask

  // Called at posedge+1; presents one event for exactly one clock edge
  task automatic ev(input logic [7:0] d, input logic l, input logic [3:0] lb,
                    input logic e, input logic c, input logic nc, input logic v);
    in_data = d; in_last = l; in_lastb = lb; in_err = e; in_col = c;
    no_card = nc; in_valid = v;
    @(posedge clk); #1;
    in_valid = 1'b0; no_card = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (n < 3000 && !(emp == 4'hF && ov == 4'h0)) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  task automatic mdl(input logic [7:0] d, input logic l, input logic [3:0] lb,
                     input logic e, input logic c, input logic nc);
    if (nc) begin
      e0.push_back(8'h6E); e0.push_back(8'h0A);
      e1.push_back(8'h6E); e1.push_back(8'h0D); e1.push_back(8'h0A);
      e2.push_back(8'h00); e2.push_back(8'h98);
    end else begin
      e0.push_back(hx(d[7:4])); e0.push_back(hx(d[3:0]));
      e1.push_back(hx(d[7:4])); e1.push_back(hx(d[3:0]));
      if (e || c || lb != 4'd8) begin
        e0.push_back(e ? 8'h65 : c ? 8'h63 : 8'h3A); e0.push_back(hx(lb));
        e1.push_back(e ? 8'h65 : c ? 8'h63 : 8'h3A); e1.push_back(hx(lb));
      end
      if (l) begin
        e0.push_back(8'h0A); e1.push_back(8'h0D); e1.push_back(8'h0A);
      end else begin
        e0.push_back(8'h20); e1.push_back(8'h20);
      end
      e2.push_back(d); e2.push_back({l, e, c, 1'b0, lb});
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [3:0] rlb;
    logic       rl, re, rc, rn;

    rst = 1'b1; in_valid = 1'b0; no_card = 1'b0; in_data = 8'h00; in_last = 1'b0;
    in_lastb = 4'd8; in_err = 1'b0; in_col = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", {28'h0, ov}, 0);
    chk("rst.out_byte", {24'h0, ob[0]}, 0);
    chk("rst.overflow", {28'h0, ovf}, 0);
    chk("rst.fifo_empty", {28'h0, emp}, 32'hF);
    rst = 1'b0;
    @(posedge clk); #1;

    // single full last byte, with latency check
    clrq(); out_ready = 1'b1;
    in_data = 8'h3C; in_last = 1'b1; in_lastb = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("lat.t0", {31'h0, ov[0]}, 0);
    @(posedge clk); #1;
    chk("lat.t1", {31'h0, ov[0]}, 0);
    @(posedge clk); #1;
    chk("lat.t2", {31'h0, ov[0]}, 1);
    chk("lat.t2.byte", {24'h0, ob[0]}, 32'h33);
    drain();
    xq = '{8'h33, 8'h43, 8'h0A};               cmp_q("t1.d0", q0, xq);
    xq = '{8'h33, 8'h43, 8'h0D, 8'h0A};        cmp_q("t1.d1", q1, xq);
    xq = '{8'h3C, 8'h88};                      cmp_q("t1.d2", q2, xq);

    // two-byte frame, partial last byte, no bubble
    clrq();
    ev(8'h26, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    ev(8'h04, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    xq = '{8'h32, 8'h36, 8'h20, 8'h30, 8'h34, 8'h3A, 8'h34, 8'h0A};
    cmp_q("t2.d0", q0, xq);
    if (tq0.size() == 8) chk("t2.nobubble", tq0[7] - tq0[0], 7);
    xq = '{8'h32, 8'h36, 8'h20, 8'h30, 8'h34, 8'h3A, 8'h34, 8'h0D, 8'h0A};
    cmp_q("t2.d1", q1, xq);
    xq = '{8'h26, 8'h08, 8'h04, 8'h84};        cmp_q("t2.d2", q2, xq);

    // no-card then error frame
    clrq();
    ev(8'h55, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    ev(8'hA5, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    xq = '{8'h6E, 8'h0A, 8'h41, 8'h35, 8'h65, 8'h33, 8'h0A};
    cmp_q("t3.d0", q0, xq);
    xq = '{8'h6E, 8'h0D, 8'h0A, 8'h41, 8'h35, 8'h65, 8'h33, 8'h0D, 8'h0A};
    cmp_q("t3.d1", q1, xq);
    xq = '{8'h00, 8'h98, 8'hA5, 8'hC3};        cmp_q("t3.d2", q2, xq);

    // collision frame
    clrq();
    ev(8'h93, 1'b1, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    xq = '{8'h39, 8'h33, 8'h63, 8'h38, 8'h0A}; cmp_q("t4.d0", q0, xq);
    xq = '{8'h93, 8'hA8};                      cmp_q("t4.d2", q2, xq);

    // overflow of the 4-deep instance under stall
    clrq(); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) ev(8'h10 + 8'(i), 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("ovf.d3", {31'h0, ovf[3]}, 1);
    chk("ovf.d0", {31'h0, ovf[0]}, 0);
    chk("hold.valid", {31'h0, ov[3]}, 1);
    chk("hold.byte0", {24'h0, ob[3]}, 32'h31);
    @(posedge clk); #1;
    chk("hold.byte1", {24'h0, ob[3]}, 32'h31);
    out_ready = 1'b1;
    drain();
    xq = '{8'h31, 8'h30, 8'h0A, 8'h31, 8'h31, 8'h0A, 8'h31, 8'h32, 8'h0A,
           8'h31, 8'h33, 8'h0A};
    cmp_q("ovf.d3q", q3, xq);
    chk("ovf.sticky", {31'h0, ovf[3]}, 1);
    xq = '{8'h31, 8'h30, 8'h0A, 8'h31, 8'h31, 8'h0A, 8'h31, 8'h32, 8'h0A,
           8'h31, 8'h33, 8'h0A, 8'h31, 8'h34, 8'h0A};
    cmp_q("ovf.d0q", q0, xq);

    // byte and no_card together: byte dropped, overflow raised
    clrq();
    ev(8'h77, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    chk("both.ovf", {31'h0, ovf[0]}, 1);
    xq = '{8'h6E, 8'h0A};                      cmp_q("both.d0", q0, xq);

    // random backpressure against the reference model
    clrq(); e0.delete(); e1.delete(); e2.delete();
    for (int k = 0; k < 40; k++) begin
      rn  = ($urandom_range(0, 7) == 0);
      rl  = 1'($urandom_range(0, 1));
      rlb = rl ? 4'($urandom_range(1, 8)) : 4'd8;
      re  = rl & ($urandom_range(0, 3) == 0);
      rc  = rl & !re & ($urandom_range(0, 3) == 0);
      rd  = 8'($urandom);
      mdl(rd, rl, rlb, re, rc, rn);
      out_ready = 1'($urandom_range(0, 1));
      ev(rd, rl, rlb, re, rc, rn, !rn);
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    drain();
    cmp_q("rnd.d0", q0, e0);
    cmp_q("rnd.d1", q1, e1);
    cmp_q("rnd.d2", q2, e2);

    // reset in the middle of an entry
    clrq(); out_ready = 1'b0;
    ev(8'h3C, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    ev(8'h5A, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("prerst.valid", {31'h0, ov[0]}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.out_valid", {28'h0, ov}, 0);
    chk("midrst.fifo_empty", {28'h0, emp}, 32'hF);
    chk("midrst.overflow", {28'h0, ovf}, 0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst.flushed", {28'h0, ov}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
